// File: rtl/rr_priority_encoder_pkg.sv
// ---------------------------------------------------------------------------
// rr_priority_encoder_pkg
// Shared constants for the round-robin / fixed priority encoder:
//   - arbitration mode encodings (value of the 'mode' input)
//   - FSM state encoding
// ---------------------------------------------------------------------------
package rr_priority_encoder_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_priority_encoder_priority_find_n.sv
// ---------------------------------------------------------------------------
// priority_find_n
// Combinational search for the first set request bit, scanning downward from
// 'start' and wrapping from index 0 back to index N-1.
// Ports:
//   req   in  N  request vector
//   start in  W  index examined first (highest priority)
//   found out 1  at least one request bit is set
//   idx   out W  index of the winning request (0 when found=0)
// ---------------------------------------------------------------------------
module priority_find_n #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);

  int           pos_s;
  logic [W-1:0] cand_s;

  // Walk the scan order from its far end back to 'start'; the last hit
  // written is therefore the one closest to 'start', i.e. the winner.
  always_comb begin
    found  = 1'b0;
    idx    = {W{1'b0}};
    pos_s  = 0;
    cand_s = {W{1'b0}};
    for (int k = N - 1; k >= 0; k--) begin
      pos_s = int'(start) - k;
      if (pos_s < 0) begin
        pos_s = pos_s + N;
      end else begin
        pos_s = pos_s;
      end
      cand_s = W'(pos_s);
      if (req[cand_s]) begin
        found = 1'b1;
        idx   = cand_s;
      end else begin
        found = found;
        idx   = idx;
      end
    end
  end

endmodule

// File: rtl/rr_priority_encoder.sv
// ---------------------------------------------------------------------------
// rr_priority_encoder
// N-input arbiter with registered grant and grant/ack handshake. In fixed
// mode the highest requesting index wins; in round-robin mode the search
// starts at a rotating pointer that moves just below the last served
// requester when its grant is acknowledged.
// Ports:
//   clk          in  1  rising-edge clock
//   reset        in  1  synchronous active-high reset
//   req          in  N  request vector
//   mode         in  1  0 = fixed priority, 1 = round-robin (used in IDLE)
//   ack          in  1  consumer done with current grant
//   grant_valid  out 1  a grant is held
//   grant_idx    out W  index of granted requester (holds after release)
//   grant_onehot out N  one-hot grant, zero when no grant is held
//   z            out 1  registered OR of req
// ---------------------------------------------------------------------------
module rr_priority_encoder
  import rr_priority_encoder_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         ack,
  output logic         grant_valid,
  output logic [W-1:0] grant_idx,
  output logic [N-1:0] grant_onehot,
  output logic         z
);

  localparam logic [W-1:0] LAST_IDX   = W'(N - 1);
  localparam logic [N-1:0] ONEHOT_LSB = {{(N - 1){1'b0}}, 1'b1};

  state_t       state_r;
  state_t       state_nxt_s;
  logic [W-1:0] ptr_r;
  logic [W-1:0] ptr_nxt_s;
  // Mode captured when the grant is issued, so a mode change during GRANT
  // only affects the next IDLE evaluation (including the pointer update).
  logic         mode_r;
  logic         mode_nxt_s;

  logic [W-1:0] start_s;
  logic         found_s;
  logic [W-1:0] win_idx_s;

  logic         valid_nxt_s;
  logic [W-1:0] idx_nxt_s;
  logic [N-1:0] onehot_nxt_s;

  // Search start: rotating pointer in round-robin mode, top index otherwise.
  always_comb begin
    if (mode == MODE_RR) begin
      start_s = ptr_r;
    end else begin
      start_s = LAST_IDX;
    end
  end

  priority_find_n #(
    .N(N)
  ) u_find (
    .req  (req),
    .start(start_s),
    .found(found_s),
    .idx  (win_idx_s)
  );

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          state_nxt_s = ST_GRANT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (ack) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_GRANT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, pointer and captured mode.
  always_comb begin
    valid_nxt_s  = grant_valid;
    idx_nxt_s    = grant_idx;
    onehot_nxt_s = grant_onehot;
    ptr_nxt_s    = ptr_r;
    mode_nxt_s   = mode_r;
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          valid_nxt_s  = 1'b1;
          idx_nxt_s    = win_idx_s;
          onehot_nxt_s = ONEHOT_LSB << win_idx_s;
          mode_nxt_s   = mode;
        end else begin
          valid_nxt_s  = 1'b0;
          onehot_nxt_s = {N{1'b0}};
        end
      end
      ST_GRANT: begin
        if (ack) begin
          valid_nxt_s  = 1'b0;
          onehot_nxt_s = {N{1'b0}};
          // Just-served requester drops to lowest priority.
          if (mode_r == MODE_RR) begin
            if (grant_idx == {W{1'b0}}) begin
              ptr_nxt_s = LAST_IDX;
            end else begin
              ptr_nxt_s = grant_idx - W'(1);
            end
          end else begin
            ptr_nxt_s = ptr_r;
          end
        end else begin
          valid_nxt_s = grant_valid;
        end
      end
      default: begin
        valid_nxt_s  = 1'b0;
        onehot_nxt_s = {N{1'b0}};
      end
    endcase
  end

  // State, pointer and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      ptr_r        <= LAST_IDX;
      mode_r       <= MODE_FIXED;
      grant_valid  <= 1'b0;
      grant_idx    <= {W{1'b0}};
      grant_onehot <= {N{1'b0}};
      z            <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      ptr_r        <= ptr_nxt_s;
      mode_r       <= mode_nxt_s;
      grant_valid  <= valid_nxt_s;
      grant_idx    <= idx_nxt_s;
      grant_onehot <= onehot_nxt_s;
      z            <= |req;
    end
  end

endmodule

// File: tb/tb_rr_priority_encoder.sv
// ---------------------------------------------------------------------------
// tb_rr_priority_encoder
// Directed, table-driven bench for rr_priority_encoder with N=4, plus
// hand-written sequences for the multi-cycle handshake corner cases.
// ---------------------------------------------------------------------------
module tb_rr_priority_encoder;

  localparam int N = 4;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic         mode;
  logic         ack;
  logic         grant_valid;
  logic [W-1:0] grant_idx;
  logic [N-1:0] grant_onehot;
  logic         z;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0] req;
    logic       mode;
    logic       exp_valid;
    logic [1:0] exp_idx;
  } vec_t;

  vec_t tbl[25];

  rr_priority_encoder #(.N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .mode        (mode),
    .ack         (ack),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .grant_onehot(grant_onehot),
    .z           (z)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic release_grant();
    ack = 1'b1;
    req = 4'b0000;
    tick();
    check("release_valid", grant_valid, 1'b0);
    check("release_onehot", grant_onehot, 4'b0000);
    ack = 1'b0;
    tick();
  endtask

  initial begin
    // fixed-mode sweep: highest set bit wins
    tbl[0]  = '{4'b0000, 1'b0, 1'b0, 2'd0};
    tbl[1]  = '{4'b0001, 1'b0, 1'b1, 2'd0};
    tbl[2]  = '{4'b0010, 1'b0, 1'b1, 2'd1};
    tbl[3]  = '{4'b0011, 1'b0, 1'b1, 2'd1};
    tbl[4]  = '{4'b0100, 1'b0, 1'b1, 2'd2};
    tbl[5]  = '{4'b0101, 1'b0, 1'b1, 2'd2};
    tbl[6]  = '{4'b0110, 1'b0, 1'b1, 2'd2};
    tbl[7]  = '{4'b0111, 1'b0, 1'b1, 2'd2};
    tbl[8]  = '{4'b1000, 1'b0, 1'b1, 2'd3};
    tbl[9]  = '{4'b1001, 1'b0, 1'b1, 2'd3};
    tbl[10] = '{4'b1010, 1'b0, 1'b1, 2'd3};
    tbl[11] = '{4'b1011, 1'b0, 1'b1, 2'd3};
    tbl[12] = '{4'b1100, 1'b0, 1'b1, 2'd3};
    tbl[13] = '{4'b1101, 1'b0, 1'b1, 2'd3};
    tbl[14] = '{4'b1110, 1'b0, 1'b1, 2'd3};
    tbl[15] = '{4'b1111, 1'b0, 1'b1, 2'd3};
    // round-robin from ptr=3 (untouched by fixed-mode grants)
    tbl[16] = '{4'b1111, 1'b1, 1'b1, 2'd3};  // ptr -> 2
    tbl[17] = '{4'b1111, 1'b1, 1'b1, 2'd2};  // ptr -> 1
    tbl[18] = '{4'b1111, 1'b1, 1'b1, 2'd1};  // ptr -> 0
    tbl[19] = '{4'b1111, 1'b1, 1'b1, 2'd0};  // ptr -> 3 (wrap)
    tbl[20] = '{4'b1111, 1'b1, 1'b1, 2'd3};  // ptr -> 2
    tbl[21] = '{4'b0101, 1'b1, 1'b1, 2'd2};  // ptr -> 1
    tbl[22] = '{4'b0101, 1'b1, 1'b1, 2'd0};  // ptr -> 3
    tbl[23] = '{4'b0011, 1'b1, 1'b1, 2'd1};  // ptr -> 0
    tbl[24] = '{4'b1010, 1'b1, 1'b1, 2'd3};  // scan wraps 0 -> 3, ptr -> 2

    reset = 1'b1;
    req   = 4'b0000;
    mode  = 1'b0;
    ack   = 1'b0;
    tick();
    tick();
    check("rst_valid", grant_valid, 1'b0);
    check("rst_idx", grant_idx, 2'd0);
    check("rst_onehot", grant_onehot, 4'b0000);
    check("rst_z", z, 1'b0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 25; i++) begin
      req  = tbl[i].req;
      mode = tbl[i].mode;
      tick();
      check($sformatf("vec%0d_valid", i), grant_valid, tbl[i].exp_valid);
      check($sformatf("vec%0d_z", i), z, tbl[i].req != 4'b0000);
      if (tbl[i].exp_valid) begin
        check($sformatf("vec%0d_idx", i), grant_idx, tbl[i].exp_idx);
        check($sformatf("vec%0d_onehot", i), grant_onehot, 4'b0001 << tbl[i].exp_idx);
        release_grant();
      end else begin
        check($sformatf("vec%0d_onehot", i), grant_onehot, 4'b0000);
        req = 4'b0000;
        tick();
      end
    end
    // ptr is now 2

    // fixed mode, req held, ack each grant: 3,3,3 with one idle bubble
    mode = 1'b0;
    req  = 4'b1111;
    tick();
    check("hold1_valid", grant_valid, 1'b1);
    check("hold1_idx", grant_idx, 2'd3);
    for (int g = 0; g < 2; g++) begin
      ack = 1'b1;
      tick();
      check("bubble_valid", grant_valid, 1'b0);
      ack = 1'b0;
      tick();
      check("regrant_valid", grant_valid, 1'b1);
      check("regrant_idx", grant_idx, 2'd3);
    end
    release_grant();

    // grant held while req changes; requester 1 drops before ack
    req = 4'b0010;
    tick();
    check("stable_idx0", grant_idx, 2'd1);
    req = 4'b1000;
    tick();
    tick();
    check("stable_valid", grant_valid, 1'b1);
    check("stable_idx", grant_idx, 2'd1);
    check("stable_onehot", grant_onehot, 4'b0010);
    check("stable_z", z, 1'b1);
    ack = 1'b1;
    tick();
    check("ack_valid", grant_valid, 1'b0);
    check("ack_idx_hold", grant_idx, 2'd1);
    check("ack_onehot", grant_onehot, 4'b0000);
    ack = 1'b0;
    tick();
    check("next_valid", grant_valid, 1'b1);
    check("next_idx", grant_idx, 2'd3);
    check("next_onehot", grant_onehot, 4'b1000);
    release_grant();

    // ack while idle is ignored, z follows empty req
    ack = 1'b1;
    tick();
    check("idle_ack_valid", grant_valid, 1'b0);
    check("idle_ack_z", z, 1'b0);
    ack = 1'b0;

    // fixed-mode grants leave ptr (=2) alone
    mode = 1'b0;
    req  = 4'b0011;
    tick();
    check("fix_idx", grant_idx, 2'd1);
    release_grant();
    mode = 1'b1;
    req  = 4'b1111;
    tick();
    check("rr_after_fix_idx", grant_idx, 2'd2);
    release_grant();
    // ptr is now 1

    // reset while granted: outputs clear, ptr returns to 3
    req = 4'b0001;
    tick();
    check("pre_rst_valid", grant_valid, 1'b1);
    check("pre_rst_idx", grant_idx, 2'd0);
    reset = 1'b1;
    req   = 4'b1111;
    ack   = 1'b0;
    tick();
    check("midrst_valid", grant_valid, 1'b0);
    check("midrst_idx", grant_idx, 2'd0);
    check("midrst_onehot", grant_onehot, 4'b0000);
    check("midrst_z", z, 1'b0);
    reset = 1'b0;
    tick();
    check("post_rst_valid", grant_valid, 1'b1);
    check("post_rst_idx", grant_idx, 2'd3);
    check("post_rst_onehot", grant_onehot, 4'b1000);
    release_grant();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
